// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
//   Shared AHB3-Lite definitions for the SRAM slave and the master-side
//   models: signal widths, HTRANS/HRESP encodings, the slave FSM state type
//   and the HSIZE -> byte-count helper.
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

   localparam int HTRANS_SIZE = 2;
   localparam int HSIZE_SIZE  = 3;
   localparam int HBURST_SIZE = 3;
   localparam int HPROT_SIZE  = 4;

   localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [HTRANS_SIZE-1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   // Number of bytes moved by a transfer of the given HSIZE encoding.
   function automatic int bytes_per_size(input logic [HSIZE_SIZE-1:0] hsize);
      return 1 << hsize;
   endfunction

endpackage

// File: rtl/ahb3lite_slv_be.sv
// ---------------------------------------------------------------------------
// ahb3lite_slv_be
//   Combinational byte-enable generator for the SRAM slave.
//   Ports:
//     hsize  in  HSIZE encoding of the transfer
//     offset in  byte offset within the data word
//     be     out one enable per byte lane of HDATA_SIZE
//   Sizes at or above the bus width enable the whole word. Offsets are not
//   alignment-checked; lanes that would fall past the top of the word are
//   simply dropped.
// ---------------------------------------------------------------------------
module ahb3lite_slv_be
   import ahb3lite_pkg::*;
#(
   parameter int HDATA_SIZE = 32,
   parameter int OFF_W      = $clog2(HDATA_SIZE/8)
)(
   input  logic [HSIZE_SIZE-1:0]   hsize,
   input  logic [OFF_W-1:0]        offset,
   output logic [HDATA_SIZE/8-1:0] be
);

   localparam int BYTES = HDATA_SIZE/8;

   int nbytes;

   always_comb begin
      nbytes = bytes_per_size(hsize);
      be     = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (nbytes >= BYTES)
            be[i] = 1'b1;
         else if ((i >= int'(offset)) && (i < int'(offset) + nbytes))
            be[i] = 1'b1;
      end
   end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_slave
//   AHB3-Lite slave backed by a word-addressed register-array memory with
//   programmable wait states and byte/halfword/word write lanes.
//   Ports:
//     HRESETn, HCLK                    async active-low reset, clock
//     HSEL, HADDR, HWRITE, HSIZE,
//     HBURST, HPROT, HTRANS, HMASTLOCK address-phase inputs (HBURST, HPROT,
//                                      HMASTLOCK are ignored)
//     HWDATA                           write data (data phase)
//     HREADY                           bus-level ready
//     HRDATA, HREADYOUT, HRESP         slave response
//   Build option:
//     AHB3LITE_SRAM_ERR_EN  defined: out-of-range word index gets a two-cycle
//                           ERROR response; undefined: index wraps modulo
//                           MEM_DEPTH and ERR states are not built.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no data phase; ready, OKAY
//   ST_DATA | data phase; ready when wait counter reaches zero
//   ST_ERR1 | first ERROR cycle; not ready
//   ST_ERR2 | second ERROR cycle; ready, next address phase taken
// ---------------------------------------------------------------------------
module ahb3lite_sram_slave
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE  = 16,
   parameter int HDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
)(
   input  logic                   HRESETn,
   input  logic                   HCLK,
   input  logic                   HSEL,
   input  logic [HADDR_SIZE-1:0]  HADDR,
   input  logic [HDATA_SIZE-1:0]  HWDATA,
   output logic [HDATA_SIZE-1:0]  HRDATA,
   input  logic                   HWRITE,
   input  logic [HSIZE_SIZE-1:0]  HSIZE,
   input  logic [HBURST_SIZE-1:0] HBURST,
   input  logic [HPROT_SIZE-1:0]  HPROT,
   input  logic [HTRANS_SIZE-1:0] HTRANS,
   input  logic                   HMASTLOCK,
   input  logic                   HREADY,
   output logic                   HREADYOUT,
   output logic                   HRESP
);

   localparam int BYTES = HDATA_SIZE/8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   state_t                  state, state_nxt, addr_nxt;
   logic [3:0]              cnt;
   logic [IDX_W-1:0]        idx_q;
   logic [OFF_W-1:0]        off_q;
   logic [HSIZE_SIZE-1:0]   size_q;
   logic                    write_q;
   logic [BYTES-1:0]        be;
   logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];

   logic                    accept, in_range, take_addr, data_done;
   logic [HADDR_SIZE-1:0]   word_addr;

   assign accept    = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
   assign word_addr = HADDR >> OFF_W;
   assign data_done = (state == ST_DATA) && (cnt == 4'd0);

`ifdef AHB3LITE_SRAM_ERR_EN
   assign in_range  = (32'(word_addr) < 32'(MEM_DEPTH));
   assign take_addr = (state == ST_IDLE) | data_done | (state == ST_ERR2);
`else
   assign in_range  = 1'b1;
   assign take_addr = (state == ST_IDLE) | data_done;
`endif

   always_comb begin
      addr_nxt = ST_IDLE;
      if (accept)
         addr_nxt = in_range ? ST_DATA : ST_ERR1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = addr_nxt;
         ST_DATA: if (cnt == 4'd0) state_nxt = addr_nxt;
`ifdef AHB3LITE_SRAM_ERR_EN
         ST_ERR1: state_nxt = ST_ERR2;
         ST_ERR2: state_nxt = addr_nxt;
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         idx_q   <= '0;
         off_q   <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take_addr && accept) begin
            idx_q   <= word_addr[IDX_W-1:0];
            off_q   <= HADDR[OFF_W-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
         end
         if (take_addr && accept && in_range)
            cnt <= 4'(WAIT_STATES);
         else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   ahb3lite_slv_be #(
      .HDATA_SIZE (HDATA_SIZE),
      .OFF_W      (OFF_W)
   ) u_be (
      .hsize  (size_q),
      .offset (off_q),
      .be     (be)
   );

   // Memory has no reset; a reset forces ST_IDLE, which blocks any pending write.
   always_ff @(posedge HCLK) begin
      if (data_done && write_q) begin
         for (int i = 0; i < BYTES; i++)
            if (be[i]) mem[idx_q][i*8 +: 8] <= HWDATA[i*8 +: 8];
      end
   end

   assign HRDATA = ((state == ST_DATA) && !write_q) ? mem[idx_q] : '0;

   always_comb begin
      HREADYOUT = 1'b1;
      case (state)
         ST_DATA: HREADYOUT = (cnt == 4'd0);
`ifdef AHB3LITE_SRAM_ERR_EN
         ST_ERR1: HREADYOUT = 1'b0;
`endif
         default: HREADYOUT = 1'b1;
      endcase
   end

`ifdef AHB3LITE_SRAM_ERR_EN
   assign HRESP = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
   assign HRESP = HRESP_OKAY;
`endif

   logic unused_ok;
   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, word_addr};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_sram_slave
//   Two slaves on private buses: index 0 with no wait states, index 1 with
//   three. Beats are queued, driven pipelined by run_seq, and each accepted
//   beat pushes its predicted response; the response is popped and compared
//   when the slave completes the data phase.
// ---------------------------------------------------------------------------
module tb_ahb3lite_sram_slave;
   import ahb3lite_pkg::*;

   localparam int NDUT = 2;

   logic hclk = 1'b0;
   always #5 hclk = ~hclk;

   logic                   hresetn   [NDUT];
   logic                   hsel      [NDUT];
   logic [15:0]            haddr     [NDUT];
   logic [31:0]            hwdata    [NDUT];
   logic [31:0]            hrdata    [NDUT];
   logic                   hwrite    [NDUT];
   logic [HSIZE_SIZE-1:0]  hsize     [NDUT];
   logic [HBURST_SIZE-1:0] hburst    [NDUT];
   logic [HPROT_SIZE-1:0]  hprot     [NDUT];
   logic [HTRANS_SIZE-1:0] htrans    [NDUT];
   logic                   hmastlock [NDUT];
   logic                   hreadyout [NDUT];
   logic                   hresp     [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ahb3lite_sram_slave #(
         .HADDR_SIZE  (16),
         .HDATA_SIZE  (32),
         .MEM_DEPTH   (256),
         .WAIT_STATES ((g == 0) ? 0 : 3)
      ) u_dut (
         .HRESETn   (hresetn[g]),
         .HCLK      (hclk),
         .HSEL      (hsel[g]),
         .HADDR     (haddr[g]),
         .HWDATA    (hwdata[g]),
         .HRDATA    (hrdata[g]),
         .HWRITE    (hwrite[g]),
         .HSIZE     (hsize[g]),
         .HBURST    (hburst[g]),
         .HPROT     (hprot[g]),
         .HTRANS    (htrans[g]),
         .HMASTLOCK (hmastlock[g]),
         .HREADY    (hreadyout[g]),
         .HREADYOUT (hreadyout[g]),
         .HRESP     (hresp[g])
      );
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, act, exp);
   endtask

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [15:0] addr;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic        rd;
      logic        err;
      logic [31:0] data;
      int          waits;
   } exp_t;

   beat_t       beat_q [$];
   exp_t        exp_q  [$];
   logic [31:0] model  [int];

   task automatic add(input logic sel, input logic [1:0] trans, input logic write,
                      input logic [15:0] addr, input logic [2:0] size,
                      input logic [2:0] burst, input logic [31:0] wdata);
      beat_t b;
      b.sel = sel; b.trans = trans; b.write = write; b.addr = addr;
      b.size = size; b.burst = burst; b.wdata = wdata;
      beat_q.push_back(b);
   endtask

   // Reference behaviour of one accepted beat; also updates the memory model.
   function automatic exp_t predict(input int k, input beat_t b);
      exp_t        e;
      int          word, key, nb, lane;
      logic [31:0] w;
      word    = int'(b.addr) >> 2;
      e.rd    = !b.write;
      e.err   = 1'b0;
      e.data  = 32'h0;
      e.waits = (k == 0) ? 0 : 3;
      if (word >= 256) begin
`ifdef AHB3LITE_SRAM_ERR_EN
         e.rd    = 1'b0;
         e.err   = 1'b1;
         e.waits = 1;
         return e;
`else
         word = word % 256;
`endif
      end
      key = k*256 + word;
      if (b.write) begin
         w  = model.exists(key) ? model[key] : 32'h0;
         nb = 1 << b.size;
         for (int n = 0; n < 4; n++) begin
            lane = (nb >= 4) ? n : int'(b.addr[1:0]) + n;
            if ((nb >= 4 || n < nb) && lane < 4) w[lane*8 +: 8] = b.wdata[lane*8 +: 8];
         end
         model[key] = w;
      end else begin
         e.data = model[key];
      end
      return e;
   endfunction

   task automatic drive_idle(input int k);
      hsel[k]   = 1'b0;
      htrans[k] = HTRANS_IDLE;
      hwrite[k] = 1'b0;
      hburst[k] = 3'b000;
   endtask

   task automatic run_seq(input int k);
      beat_t       b;
      exp_t        e;
      bit          in_data = 1'b0;
      bit          adv     = 1'b0;
      bit          rdy;
      int          nwait   = 0;
      logic [31:0] wd_pend = 32'h0;
      while (beat_q.size() > 0 || in_data) begin
         @(negedge hclk);
         if (adv) hwdata[k] = wd_pend;
         rdy = hreadyout[k];
         if (in_data) begin
            e = exp_q[0];
            chk($sformatf("d%0d hresp", k), hresp[k], e.err);
            if (!e.rd) chk($sformatf("d%0d hrdata_zero", k), hrdata[k], 32'h0);
            if (rdy) begin
               void'(exp_q.pop_front());
               chk($sformatf("d%0d wait_cycles", k), nwait, e.waits);
               if (e.rd) chk($sformatf("d%0d hrdata", k), hrdata[k], e.data);
               in_data = 1'b0;
            end else begin
               nwait++;
               if (nwait > 40) begin
                  n_chk++;
                  $display("FAIL d%0d timeout: HREADYOUT low for %0d cycles, limit 40", k, nwait);
                  beat_q.delete();
                  exp_q.delete();
                  drive_idle(k);
                  return;
               end
            end
         end else begin
            chk($sformatf("d%0d idle_ready", k), rdy, 1'b1);
            chk($sformatf("d%0d idle_resp", k), hresp[k], HRESP_OKAY);
            chk($sformatf("d%0d idle_rdata", k), hrdata[k], 32'h0);
         end
         adv = rdy;
         if (rdy) begin
            if (beat_q.size() > 0) begin
               b         = beat_q.pop_front();
               hsel[k]   = b.sel;
               htrans[k] = b.trans;
               hwrite[k] = b.write;
               haddr[k]  = b.addr;
               hsize[k]  = b.size;
               hburst[k] = b.burst;
               if (b.sel && b.trans[1]) begin
                  exp_q.push_back(predict(k, b));
                  wd_pend = b.wdata;
                  in_data = 1'b1;
                  nwait   = 0;
               end
            end else begin
               drive_idle(k);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         hresetn[k]   = 1'b0;
         hwdata[k]    = 32'h0;
         haddr[k]     = 16'h0;
         hsize[k]     = 3'd2;
         hprot[k]     = 4'b0011;
         hmastlock[k] = 1'b0;
         drive_idle(k);
      end
      repeat (2) @(negedge hclk);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("d%0d rst_ready", k), hreadyout[k], 1'b1);
         chk($sformatf("d%0d rst_resp", k), hresp[k], HRESP_OKAY);
         chk($sformatf("d%0d rst_rdata", k), hrdata[k], 32'h0);
         hresetn[k] = 1'b1;
      end

      for (int k = 0; k < NDUT; k++) begin
         // pipelined write then read of the same word
         add(1, HTRANS_NONSEQ, 1, 16'h0010, 3'd2, 3'b000, 32'hDEADBEEF);
         add(1, HTRANS_NONSEQ, 0, 16'h0010, 3'd2, 3'b000, 32'h0);
         // byte and halfword lanes, each read back immediately
         add(1, HTRANS_NONSEQ, 1, 16'h0020, 3'd2, 3'b000, 32'h11223344);
         add(1, HTRANS_NONSEQ, 1, 16'h0021, 3'd0, 3'b000, 32'h0000AA00);
         add(1, HTRANS_NONSEQ, 0, 16'h0020, 3'd2, 3'b000, 32'h0);
         add(1, HTRANS_NONSEQ, 1, 16'h0022, 3'd1, 3'b000, 32'h55660000);
         add(1, HTRANS_NONSEQ, 0, 16'h0020, 3'd2, 3'b000, 32'h0);
         // oversize HSIZE writes the full word
         add(1, HTRANS_NONSEQ, 1, 16'h0030, 3'd3, 3'b000, 32'h0BADCAFE);
         add(1, HTRANS_NONSEQ, 0, 16'h0030, 3'd2, 3'b000, 32'h0);
         // out-of-range write, then read of word 0
         add(1, HTRANS_NONSEQ, 1, 16'h0000, 3'd2, 3'b000, 32'hCAFEF00D);
         add(1, HTRANS_NONSEQ, 1, 16'h0400, 3'd2, 3'b000, 32'h12345678);
         add(1, HTRANS_NONSEQ, 0, 16'h0000, 3'd2, 3'b000, 32'h0);
         run_seq(k);

         // INCR4 write with a BUSY beat, deselected and idle cycles, INCR4 read
         add(1, HTRANS_NONSEQ, 1, 16'h0040, 3'd2, 3'b011, 32'hA0A0A0A0);
         add(1, HTRANS_SEQ,    1, 16'h0044, 3'd2, 3'b011, 32'hA1A1A1A1);
         add(1, HTRANS_BUSY,   1, 16'h0048, 3'd2, 3'b011, 32'hFFFFFFFF);
         add(1, HTRANS_SEQ,    1, 16'h0048, 3'd2, 3'b011, 32'hA2A2A2A2);
         add(1, HTRANS_SEQ,    1, 16'h004C, 3'd2, 3'b011, 32'hA3A3A3A3);
         add(0, HTRANS_NONSEQ, 1, 16'h0040, 3'd2, 3'b000, 32'hEEEEEEEE);
         add(1, HTRANS_IDLE,   1, 16'h0044, 3'd2, 3'b000, 32'hEEEEEEEE);
         add(1, HTRANS_NONSEQ, 0, 16'h0040, 3'd2, 3'b011, 32'h0);
         add(1, HTRANS_SEQ,    0, 16'h0044, 3'd2, 3'b011, 32'h0);
         add(1, HTRANS_BUSY,   0, 16'h0048, 3'd2, 3'b011, 32'h0);
         add(1, HTRANS_SEQ,    0, 16'h0048, 3'd2, 3'b011, 32'h0);
         add(1, HTRANS_SEQ,    0, 16'h004C, 3'd2, 3'b011, 32'h0);
         add(1, HTRANS_NONSEQ, 1, 16'h0050, 3'd2, 3'b000, 32'h600DF00D);
         run_seq(k);
      end

      // reset during the second wait cycle of a write on the wait-state slave
      @(negedge hclk);
      hsel[1]   = 1'b1;
      haddr[1]  = 16'h0050;
      hwrite[1] = 1'b1;
      hsize[1]  = 3'd2;
      htrans[1] = HTRANS_NONSEQ;
      @(negedge hclk);
      hwdata[1] = 32'hBAD0BAD0;
      drive_idle(1);
      chk("d1 rst_mid wait1_ready", hreadyout[1], 1'b0);
      @(negedge hclk);
      chk("d1 rst_mid wait2_ready", hreadyout[1], 1'b0);
      #2 hresetn[1] = 1'b0;
      #1;
      chk("d1 rst_mid async_ready", hreadyout[1], 1'b1);
      chk("d1 rst_mid async_resp", hresp[1], HRESP_OKAY);
      @(negedge hclk);
      hresetn[1] = 1'b1;
      add(1, HTRANS_NONSEQ, 0, 16'h0050, 3'd2, 3'b000, 32'h0);
      run_seq(1);

      @(negedge hclk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ahb3lite_sram_slave.md
# ahb3lite_sram_slave

Synthesizable AHB3-Lite slave responding to transfers with an internal word-addressed register-array memory. It sits on the slave side of the AHB3-Lite interconnect and serves as the on-chip scratch memory and the DUT-side counterpart for master bus functional models. It supports:

- programmable wait states
- byte/halfword/word lanes
- an optional two-cycle ERROR response for out-of-range addresses

## Interface

- HADDR_SIZE, 16, address width
- HDATA_SIZE, 32, data width; multiple of 8
- MEM_DEPTH, 256, memory size in HDATA_SIZE-bit words; power of two
- WAIT_STATES, 0, wait cycles inserted in every data phase; 0..15

Reset and clock: one clock; reset is asynchronous and active-low.

- HRESETn  in  1  asynchronous active-low reset
- HCLK  in  1  clock, rising edge
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  address
- HWDATA  in  HDATA_SIZE  write data
- HRDATA  out  HDATA_SIZE  read data
- HWRITE  in  1  1=write
- HSIZE  in  HSIZE_SIZE  transfer size
- HBURST  in  HBURST_SIZE  burst type; ignored (addresses taken per beat)
- HPROT  in  HPROT_SIZE  ignored
- HTRANS  in  HTRANS_SIZE  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus-level ready (muxed)
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  HRESP_OKAY / HRESP_ERROR

## Operation

**Address phase accept.** An address phase is accepted on a rising edge when `HSEL & HREADY & (HTRANS==NONSEQ | HTRANS==SEQ)`. On accept, the following are latched:

- word index `HADDR/(HDATA_SIZE/8)`
- byte offset
- HSIZE
- HWRITE

**Non-accepted phases.** IDLE and BUSY, or `HSEL=0`, cause no data phase: OKAY, zero wait, no memory access.

**States.**

- **IDLE**
  - HREADYOUT=1, HRESP=OKAY.
- **DATA**
  - On entry, wait counter loaded with WAIT_STATES.
  - HREADYOUT = (cnt==0); HRESP=OKAY.
  - cnt decrements each cycle while nonzero.
  - On the cycle with cnt==0 the transfer completes.
- **ERR1**
  - HREADYOUT=0, HRESP=ERROR.
  - Always proceeds to ERR2.
- **ERR2**
  - HREADYOUT=1, HRESP=ERROR.

**Transitions.** From IDLE, from DATA with cnt==0, and from ERR2, the next state is taken from the current address phase:

- accept, in range → DATA
- accept, out of range (macro enabled) → ERR1
- otherwise → IDLE

**Writes.**

- Committed at the rising edge ending the completing DATA cycle.
- Written bytes: `HWDATA[(offset+n)*8 +: 8]` for n in 0 .. bytes(HSIZE)-1, into the latched word.
- Unwritten bytes are retained.
- HSIZE wider than HDATA_SIZE is treated as a full word.
- Offset is not alignment-checked.

**Reads.**

- HRDATA = memory word at the latched index, driven combinationally throughout a read DATA state, so it sees the write committed at the previous edge.
- HRDATA=0 outside a read data phase.
- Full word is returned; the master selects lanes.

**Error/range handling.**

- ERROR states never write memory.
- Out-of-range: word index ≥ MEM_DEPTH.

## Timing

**Reset values.**

- HREADYOUT=1, HRESP=OKAY, HRDATA=0.
- State IDLE, cnt=0.
- Memory contents not reset.

**Reset mid-operation.**

- Reset asserted mid-wait or mid-ERROR: the pending transfer is dropped with no write.
- Outputs reach reset values asynchronously.

**Latency.**

- Data phase occupies WAIT_STATES+1 cycles after accept.
- Back-to-back transfers are pipelined: the next address phase is accepted on the same edge the current data phase completes.

**ERROR response.**

- Exactly 2 cycles.
- An address phase presented during ERR2 is honoured. Masters normally drive IDLE there, yielding IDLE.

**Read-after-write.** Read of a word written by the immediately preceding transfer returns the new data.

## Configuration

**AHB3LITE_SRAM_ERR_EN**

- Defined: out-of-range accesses get the ERR1/ERR2 response.
- Undefined: the word index wraps modulo MEM_DEPTH, the access completes as a normal OKAY data phase, and ERR states are not synthesized.

## Structure

**Shared package.** Add to ahb3lite_pkg:

- State typedef (ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2).
- Function bytes-per-size, shared with masters.

**Sub-module.** One sub-module, ahb3lite_slv_be: combinational byte-enable generator (HSIZE, byte offset → HDATA_SIZE/8 enable bits).

## Test plan

1. **Zero-wait pipelined write/read.** WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back → HREADYOUT stays 1; read data phase HRDATA=0xDEADBEEF.
2. **Wait states.** WAIT_STATES=3: single read → HREADYOUT low exactly 3 cycles, high on 4th with valid HRDATA.
3. **Byte lanes.** Write byte 0xAA @0x21 onto word 0x11223344 @0x20 → readback 0x1122AA44; halfword 0x5566 @0x22 → 0x5566AA44.
4. **ERROR path.** With ERR_EN, MEM_DEPTH=256: write @0x400 → HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; subsequent read of 0x000 shows memory unchanged. Without the macro, the same write lands at word 0.
5. **BUSY/IDLE and deselect.** INCR4 with a BUSY beat inserted, and `HSEL=0` cycles → BUSY/IDLE get zero-wait OKAY; 4 data beats correct.
6. **Reset mid-wait.** Assert HRESETn low during the 2nd wait cycle of a write → HREADYOUT=1 immediately; target word unchanged after release.
